// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci LFSR stream, then flywheels
// on its own prediction to count bit errors and detect loss of lock.
module prbs_checker #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1101,
  parameter int unsigned      LOCK_CNT    = 8,
  parameter int unsigned      LOSS_THRESH = 4,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             lock_lost
);

  localparam int unsigned FW = $clog2(WIDTH + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_THRESH + 1);

  localparam logic [FW-1:0] FillLast = FW'(WIDTH - 1);
  localparam logic [MW-1:0] LockLast = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LossLast = LW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {StFill, StSearch, StLocked} state_t;

  state_t          state;
  logic [WIDTH-1:0] hist;
  logic [FW-1:0]   fill_cnt;
  logic [MW-1:0]   match_cnt;
  logic [LW-1:0]   miss_cnt;

  logic pred;
  logic match;
  logic loss;

  always_comb begin
    pred  = ^(hist & TAPS);
    match = (din == pred);
    loss  = din_valid && (state == StLocked) && !match && (miss_cnt == LossLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StFill;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
      lock_lost <= 1'b0;
    end else begin
      err <= 1'b0;
      if (din_valid) begin
        case (state)
          StFill: begin
            hist <= {hist[WIDTH-2:0], din};
            if (fill_cnt == FillLast) begin
              state     <= StSearch;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          StSearch: begin
            hist <= {hist[WIDTH-2:0], din};
            // An all-zero history predicts zero forever; never count it toward lock.
            if (match && (hist != '0)) begin
              if (match_cnt == LockLast) begin
                state     <= StLocked;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          StLocked: begin
            // Flywheel: feed back the prediction so a flipped bit costs one error.
            hist <= {hist[WIDTH-2:0], pred};
            if (bit_count != '1) bit_count <= bit_count + 1'b1;
            if (!match) begin
              err <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (miss_cnt == LossLast) begin
                state     <= StFill;
                locked    <= 1'b0;
                fill_cnt  <= '0;
                miss_cnt  <= '0;
                lock_lost <= 1'b1;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state  <= StFill;
            locked <= 1'b0;
          end
        endcase
      end
      // Clear overrides this beat's counter updates, but a loss of lock still registers.
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
        lock_lost <= loss;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, loss/relock, stuck-at-0,
// gapped valid with clear, and asynchronous reset while locked.
module tb_prbs_checker;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic        din;
  logic        clear;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [15:0] bit_count;
  logic        lock_lost;

  int checks;
  int errors;
  int ph;
  logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  prbs_checker dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clear     (clear),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .bit_count (bit_count),
    .lock_lost (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic v, input logic b, input logic clr);
    @(negedge clk);
    din_valid = v;
    din       = b;
    clear     = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic send(input logic inv, input logic clr);
    logic b;
    b  = pat[ph] ^ inv;
    ph = (ph + 1) % 6;
    beat(1'b1, b, clr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    din = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ph = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL reset_locked: got %0d want 0", locked);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %0d want 0", err);
    end
    checks++;
    if (err_count !== 16'd0 || bit_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", err_count, bit_count);
    end
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++; $display("FAIL reset_lock_lost: got %0d want 0", lock_lost);
    end
  endtask

  task automatic test_clean_lock();
    int pulses;
    for (int i = 1; i <= 11; i++) send(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL clean_prelock: got %0d want 0", locked);
    end
    send(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || bit_count !== 16'd0) begin
      errors++; $display("FAIL clean_lock: got locked=%0d bits=%0d want 1/0", locked, bit_count);
    end
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      send(1'b0, 1'b0);
      if (err === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL clean_err_pulses: got %0d want 0", pulses);
    end
    checks++;
    if (bit_count !== 16'd18 || err_count !== 16'd0) begin
      errors++; $display("FAIL clean_counts: got %0d/%0d want 18/0", bit_count, err_count);
    end
  endtask

  task automatic test_single_error();
    send(1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err: got err=%0d cnt=%0d locked=%0d want 1/1/1", err, err_count,
               locked);
    end
    send(1'b0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL single_err_width: got %0d want 0", err);
    end
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
    checks++;
    if (err_count !== 16'd1 || bit_count !== 16'd30 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_after: got errs=%0d bits=%0d locked=%0d want 1/30/1", err_count,
               bit_count, locked);
    end
  endtask

  task automatic test_loss_of_lock();
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd4) begin
      errors++; $display("FAIL loss_third: got locked=%0d errs=%0d want 1/4", locked, err_count);
    end
    send(1'b1, 1'b0);
    checks++;
    if (locked !== 1'b0 || lock_lost !== 1'b1 || err_count !== 16'd5) begin
      errors++;
      $display("FAIL loss_fourth: got locked=%0d lost=%0d errs=%0d want 0/1/5", locked,
               lock_lost, err_count);
    end
    for (int i = 0; i < 11; i++) send(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL relock_early: got %0d want 0", locked);
    end
    send(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || bit_count !== 16'd34 || err_count !== 16'd5) begin
      errors++;
      $display("FAIL relock: got locked=%0d bits=%0d errs=%0d want 1/34/5", locked, bit_count,
               err_count);
    end
  endtask

  task automatic test_stuck_zero();
    int seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      beat(1'b1, 1'b0, 1'b0);
      if (locked !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || err_count !== 16'd0) begin
      errors++; $display("FAIL stuck_zero: got locked_beats=%0d errs=%0d want 0/0", seen, err_count);
    end
  endtask

  task automatic test_gaps_and_clear();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send(1'b0, 1'b0);
      if (i == 11) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++; $display("FAIL gap_prelock: got %0d want 0", locked);
        end
      end
      beat(1'b0, ~din, 1'b0);
    end
    checks++;
    if (locked !== 1'b1 || bit_count !== 16'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL gap_lock: got locked=%0d bits=%0d err=%0d want 1/0/0", locked, bit_count,
               err);
    end
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b0);
      beat(1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (bit_count !== 16'd3) begin
      errors++; $display("FAIL gap_bits: got %0d want 3", bit_count);
    end
    send(1'b1, 1'b1);
    checks++;
    if (err_count !== 16'd0 || bit_count !== 16'd0 || lock_lost !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clear_mismatch: got errs=%0d bits=%0d lost=%0d locked=%0d want 0/0/0/1",
               err_count, bit_count, lock_lost, locked);
    end
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    checks++;
    if (err_count !== 16'd2 || locked !== 1'b1) begin
      errors++; $display("FAIL clear_then_err: got errs=%0d locked=%0d want 2/1", err_count, locked);
    end
    send(1'b1, 1'b1);
    checks++;
    if (locked !== 1'b0 || lock_lost !== 1'b1 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_on_loss: got locked=%0d lost=%0d errs=%0d want 0/1/0", locked,
               lock_lost, err_count);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    for (int i = 0; i < 12; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    checks++;
    if (err_count !== 16'd3 || locked !== 1'b1) begin
      errors++; $display("FAIL premid: got errs=%0d locked=%0d want 3/1", err_count, locked);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0 || bit_count !== 16'd0 ||
        lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %0d %0d %0d %0d %0d want all 0", locked, err, err_count,
               bit_count, lock_lost);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) send(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL postreset_early: got %0d want 0", locked);
    end
    send(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL postreset_relock: got %0d want 1", locked);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph = 0;
    rst = 1'b1;
    din_valid = 1'b0;
    din = 1'b0;
    clear = 1'b0;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_stuck_zero();
    test_gaps_and_clear();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
